// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped 8N1 UART transmitter sitting on the CPU data bus beside
// external memory. Byte writes to TXDATA are queued in a small FIFO and
// shifted out LSB first on tx. STATUS and BAUDDIV are readable through
// iodata, which the top level muxes onto memdata while ioSel is high.
//
// Register window (word addresses):
//   BASE_ADR+0  TXDATA   write: queue writedata[7:0]; read: 0
//   BASE_ADR+1  STATUS   read: {8'b0, count[3:0], ovr, busy, empty, full}
//                        write: writedata[3]=1 clears ovr
//   BASE_ADR+2  BAUDDIV  read/write: cycles per bit (0 and 1 load as 2)
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   memwrite     bus write strobe
//   memread      bus read strobe
//   adr          bus address
//   writedata    bus write data
//   iodata       read data, combinational, zero unless ioSel
//   ioSel        memread with adr inside the register window
//   tx           serial output, idle high, driven from a flop
//   dbg_state_o  current transmitter FSM state (debug visibility)
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADR  = 16'hFF00,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [15:0] adr,
    input  logic [15:0] writedata,
    output logic [15:0] iodata,
    output logic        ioSel,
    output logic        tx,
    output logic [1:0]  dbg_state_o
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    localparam logic [15:0] ADR_TXDATA  = BASE_ADR;
    localparam logic [15:0] ADR_STATUS  = BASE_ADR + 16'd1;
    localparam logic [15:0] ADR_BAUDDIV = BASE_ADR + 16'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Address decode
    logic hit_tx, hit_st, hit_dv;
    assign hit_tx = (adr == ADR_TXDATA);
    assign hit_st = (adr == ADR_STATUS);
    assign hit_dv = (adr == ADR_BAUDDIV);

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q;
    logic          fifo_empty, fifo_full;
    logic          push_req, push, pop;

    // Push/pop handshake: the bus side offers a byte with push_req (valid);
    // it is accepted only when the FIFO is not full as seen before the edge
    // (ready = !fifo_full), otherwise it is dropped and ovr is raised. The
    // FSM pops only when count is non-zero, so a byte written on this edge
    // is never bypassed straight into the shifter.
    assign fifo_empty = (count_q == 5'd0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign push_req   = memwrite && hit_tx;
    assign push       = push_req && !fifo_full;

    // Other registers
    logic [15:0] div_q;
    logic        ovr_q;

    // Transmitter FSM registers
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic bit_end;
    assign bit_end = (cnt_q == 16'd0);

    // Next-state logic. tx_d is the line level for the state being entered,
    // so the registered tx changes on the same edge as the state. The bit
    // counter is reloaded from div_q only when a new bit starts, which is
    // what lets a BAUDDIV write finish the current bit at the old period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    cnt_d   = div_q - 16'd1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    cnt_d   = div_q - 16'd1;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = div_q - 16'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        cnt_d   = div_q - 16'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // FIFO pointers, occupancy, sticky overrun and divisor
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 5'd0;
            ovr_q    <= 1'b0;
            div_q    <= DIV_RESET;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase

            if (push_req && fifo_full) begin
                ovr_q <= 1'b1;
            end else if (memwrite && hit_st && writedata[3]) begin
                ovr_q <= 1'b0;
            end

            if (memwrite && hit_dv) begin
                div_q <= (writedata < 16'd2) ? 16'd2 : writedata;
            end
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= writedata[7:0];
        end
    end

    // Read path
    logic busy;
    assign busy  = (state_q != S_IDLE);
    assign ioSel = memread && (hit_tx || hit_st || hit_dv);

    always_comb begin
        iodata = 16'd0;
        if (ioSel) begin
            if (hit_st) begin
                iodata = {8'd0, count_q[3:0], ovr_q, busy, fifo_empty, fifo_full};
            end else if (hit_dv) begin
                iodata = div_q;
            end
        end
    end

    assign tx          = tx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: bus driver tasks issue register accesses,
// expected bytes go into exp_q, and an independent serial monitor decodes
// frames from tx and checks them against the queue.
module tb_mmio_uart_tx;

    localparam logic [15:0] A_TX = 16'hFF00;
    localparam logic [15:0] A_ST = 16'hFF01;
    localparam logic [15:0] A_DV = 16'hFF02;

    // Clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [15:0] adr = 16'd0;
    logic [15:0] writedata = 16'd0;
    logic [15:0] iodata;
    logic        ioSel;
    logic        tx;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mmio_uart_tx #(
        .BASE_ADR (16'hFF00),
        .DEPTH    (4),
        .DIV_RESET(16'd434)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .memwrite   (memwrite),
        .memread    (memread),
        .adr        (adr),
        .writedata  (writedata),
        .iodata     (iodata),
        .ioSel      (ioSel),
        .tx         (tx),
        .dbg_state_o(dbg_state)
    );

    // Scoreboard state
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    int          mon_div = 434;
    bit          mon_en = 1'b0;
    int unsigned last_wr_cyc = 0;

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic checkn(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge, the rising edge captures.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk);
        #1;
        memwrite    = 1'b0;
        last_wr_cyc = cyc;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic sel);
        @(negedge clk);
        adr     = a;
        memread = 1'b1;
        #1;
        d       = iodata;
        sel     = ioSel;
        memread = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        logic        sel;
        bus_read(a, d, sel);
        check1({name, "_sel"}, sel, 1'b1);
        check16(name, d, exp);
    endtask

    task automatic set_div(input int d);
        bus_write(A_DV, 16'(d));
        mon_div = (d < 2) ? 2 : d;
    endtask

    task automatic wait_drain(input int limit, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        checkn({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    task automatic watch_idle(input int n, input string name);
        int lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checkn(name, lows, 0);
    endtask

    task automatic find_start(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
    endtask

    // Monitor: decodes a whole 8N1 frame at the divisor the bench set,
    // requiring every bit to hold its level for exactly mon_div cycles.
    initial begin : monitor
        logic       s[$];
        logic [7:0] got;
        logic [7:0] exp_b;
        bit         shape_ok;
        int         d;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                d = mon_div;
                start_q.push_back(cyc);
                s.delete();
                s.push_back(tx);
                for (int i = 1; i < 10 * d; i++) begin
                    @(negedge clk);
                    s.push_back(tx);
                end
                shape_ok = 1'b1;
                for (int b = 0; b < 10; b++)
                    for (int j = 0; j < d; j++)
                        if (s[b*d+j] !== s[b*d]) shape_ok = 1'b0;
                if (s[0] !== 1'b0 || s[9*d] !== 1'b1) shape_ok = 1'b0;
                got = 8'd0;
                for (int b = 0; b < 8; b++) got[b] = s[(b+1)*d];
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got byte %h expected none", got);
                end else begin
                    exp_b = exp_q.pop_front();
                    check16("rx_byte", {8'd0, got}, {8'd0, exp_b});
                    check1("rx_frame_shape", shape_ok, 1'b1);
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin : stim
        logic [15:0] d;
        logic        sel;
        logic [7:0]  b;
        logic        sm[60];
        int          runs[4];
        int          r;
        int          n;
        int          cnt;
        int          dv;
        int unsigned wr0;
        bit          found;

        // Reset then idle
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check1("reset_tx", tx, 1'b1);
        check1("reset_iosel", ioSel, 1'b0);
        check16("reset_iodata", iodata, 16'h0000);
        check16("reset_dbg_state", {14'd0, dbg_state}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        read_check("status_after_reset", A_ST, 16'h0002);
        read_check("bauddiv_after_reset", A_DV, 16'd434);
        read_check("txdata_reads_zero", A_TX, 16'h0000);

        // Single byte at BAUDDIV=4
        set_div(4);
        read_check("bauddiv_4", A_DV, 16'd4);
        mon_en = 1'b1;
        start_q.delete();
        exp_q.push_back(8'hA5);
        bus_write(A_TX, 16'h00A5);
        wr0 = last_wr_cyc;
        wait_drain(200, "single");
        checkn("start_latency", (start_q.size() > 0) ? int'(start_q[0] - wr0) : -1, 1);
        read_check("status_after_single", A_ST, 16'h0002);

        // Fill and overflow at BAUDDIV=100: first byte goes to the shifter,
        // four fill the FIFO, the sixth is dropped.
        set_div(100);
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 5) exp_q.push_back(b);
            bus_write(A_TX, {8'd0, b});
        end
        read_check("status_full_ovr", A_ST, 16'h004D);
        read_check("status_ovr_sticky", A_ST, 16'h004D);
        bus_write(A_ST, 16'h0008);
        read_check("status_ovr_cleared", A_ST, 16'h0045);
        wait_drain(7000, "overflow");
        read_check("status_after_overflow", A_ST, 16'h0002);

        // Back-to-back frames at BAUDDIV=2
        set_div(2);
        start_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h80);
        bus_write(A_TX, 16'h0001);
        bus_write(A_TX, 16'h0080);
        wait_drain(200, "b2b");
        checkn("b2b_frames", start_q.size(), 2);
        checkn("b2b_gap", (start_q.size() >= 2) ? int'(start_q[1] - start_q[0]) : -1, 20);

        // Divisor change during a data bit
        set_div(8);
        mon_en = 1'b0;
        bus_write(A_TX, 16'h0055);
        find_start(20, found);
        check1("divchg_start_seen", found, 1'b1);
        sm[0] = tx;
        fork
            begin
                for (int i = 1; i < 60; i++) begin
                    @(negedge clk);
                    sm[i] = tx;
                end
            end
            begin
                // Lands in the middle of data bit 0 (cycles 8..15 of the frame).
                repeat (11) @(posedge clk);
                bus_write(A_DV, 16'd3);
            end
        join
        mon_div = 3;
        for (int i = 0; i < 4; i++) runs[i] = 0;
        r = 0;
        for (int i = 0; i < 60; i++) begin
            if (i > 0 && sm[i] !== sm[i-1]) r++;
            if (r < 4) runs[r]++;
        end
        checkn("divchg_start_len", runs[0], 8);
        checkn("divchg_bit0_len", runs[1], 8);
        checkn("divchg_bit1_len", runs[2], 3);
        checkn("divchg_bit2_len", runs[3], 3);
        read_check("bauddiv_3", A_DV, 16'd3);
        set_div(0);
        read_check("bauddiv_0_as_2", A_DV, 16'd2);
        set_div(1);
        read_check("bauddiv_1_as_2", A_DV, 16'd2);

        // Asynchronous reset in the middle of a frame
        set_div(4);
        bus_write(A_TX, 16'h0000);
        bus_write(A_TX, 16'h000F);
        find_start(20, found);
        check1("rst_start_seen", found, 1'b1);
        repeat (6) @(negedge clk);
        check1("rst_pre_tx_low", tx, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check1("rst_mid_frame_tx", tx, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_div = 434;
        check16("rst_dbg_state", {14'd0, dbg_state}, 16'd0);
        read_check("status_after_midrst", A_ST, 16'h0002);
        read_check("bauddiv_after_midrst", A_DV, 16'd434);
        watch_idle(60, "no_residual_frame");

        // Addresses outside the window
        set_div(2);
        mon_en = 1'b1;
        bus_write(16'hFE00, 16'h0055);
        bus_write(16'hFF03, 16'h0077);
        bus_write(16'hFE02, 16'h0009);
        bus_read(16'hFE00, d, sel);
        check1("nonhit_fe00_sel", sel, 1'b0);
        check16("nonhit_fe00_data", d, 16'h0000);
        bus_read(16'hFF03, d, sel);
        check1("nonhit_ff03_sel", sel, 1'b0);
        watch_idle(40, "nonhit_no_frame");
        read_check("status_after_nonhit", A_ST, 16'h0002);
        read_check("bauddiv_after_nonhit", A_DV, 16'd2);

        // Randomized bursts: up to DEPTH+1 consecutive writes all fit because
        // the first byte moves into the shifter on the following edge.
        for (int it = 0; it < 8; it++) begin
            dv = $urandom_range(2, 6);
            set_div(dv);
            read_check("rand_bauddiv", A_DV, 16'(dv));
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                bus_write(A_TX, {8'd0, b});
            end
            cnt = (n == 1) ? 1 : n - 1;
            read_check("rand_status", A_ST,
                       {8'd0, 4'(cnt), 1'b0, (n > 1), 1'b0, (cnt == 4)});
            wait_drain(500, "rand");
            read_check("rand_status_idle", A_ST, 16'h0002);
        end

        checkn("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
